// File: rtl/i2s_tx.sv
// I2S transmitter: buffers one stereo pair and shifts it out left-justified,
// MSB first, with bclk derived from clk by an integer divider.
//
//   state | meaning
//   IDLE  | outputs parked low, waiting for enable and a held pair
//   RUN   | serialising a frame; enable is only looked at on the frame's last bit
module i2s_tx #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int BCLK_DIV     = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SAMPLE_WIDTH-1:0] in_left,
    input  logic [SAMPLE_WIDTH-1:0] in_right,
    output logic                    bclk,
    output logic                    lrclk,
    output logic                    sdata,
    output logic                    underrun
);

    localparam int FRAME_W = 2 * SAMPLE_WIDTH;
    localparam int DIV_W   = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
    localparam int BIT_W   = $clog2(FRAME_W);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);
    localparam logic [BIT_W-1:0] BIT_HALF = BIT_W'(SAMPLE_WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                    state;
    logic                      hold_full;
    logic [SAMPLE_WIDTH-1:0]   hold_left;
    logic [SAMPLE_WIDTH-1:0]   hold_right;
    logic [FRAME_W-1:0]        shreg;
    logic [DIV_W-1:0]          div_cnt;
    logic [BIT_W-1:0]          bit_cnt;

    logic run;
    assign run = (state == RUN);

    assign in_ready = !hold_full;
    assign bclk     = run && (div_cnt >= DIV_HALF);
    assign lrclk    = run && (bit_cnt >= BIT_HALF);
    assign sdata    = run && shreg[FRAME_W-1];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            hold_full  <= 1'b0;
            hold_left  <= '0;
            hold_right <= '0;
            shreg      <= '0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            underrun   <= 1'b0;
        end else begin
            underrun <= 1'b0;

            // Accept and load never coincide: accept needs the hold empty, load needs it full.
            if (in_valid && !hold_full) begin
                hold_left  <= in_left;
                hold_right <= in_right;
                hold_full  <= 1'b1;
            end

            case (state)
                IDLE: begin
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    if (enable && hold_full) begin
                        state     <= RUN;
                        shreg     <= {hold_left, hold_right};
                        hold_full <= 1'b0;
                    end
                end

                RUN: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            if (!enable) begin
                                state <= IDLE;
                                shreg <= '0;
                            end else if (hold_full) begin
                                shreg     <= {hold_left, hold_right};
                                hold_full <= 1'b0;
                            end else begin
                                shreg    <= '0;
                                underrun <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            shreg   <= {shreg[FRAME_W-2:0], 1'b0};
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx at SAMPLE_WIDTH=16, BCLK_DIV=4 (128-cycle frames).
module tb_i2s_tx;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_left;
    logic [15:0] in_right;
    logic        bclk;
    logic        lrclk;
    logic        sdata;
    logic        underrun;

    int n_checks = 0;
    int n_fail   = 0;

    i2s_tx #(.SAMPLE_WIDTH(16), .BCLK_DIV(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_left  (in_left),
        .in_right (in_right),
        .bclk     (bclk),
        .lrclk    (lrclk),
        .sdata    (sdata),
        .underrun (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at frame cycle 0 (sampled on negedge); returns at cycle 0 of the next frame.
    task automatic run_frame(input logic [15:0] l, input logic [15:0] r,
                             input bit ur0, input bit held0,
                             input int acc_at, input logic [15:0] nl, input logic [15:0] nr,
                             input int en_off_at);
        logic [31:0] word;
        word = {l, r};
        for (int i = 0; i < 128; i++) begin
            check_eq($sformatf("bclk[%0d]", i), bclk, ((i % 4) >= 2));
            check_eq($sformatf("lrclk[%0d]", i), lrclk, ((i / 4) >= 16));
            check_eq($sformatf("sdata[%0d]", i), sdata, word[31 - i / 4]);
            check_eq($sformatf("underrun[%0d]", i), underrun, ((i == 0) && ur0));
            check_eq($sformatf("in_ready[%0d]", i), in_ready,
                     !(held0 || (acc_at >= 0 && i > acc_at)));
            if (i == acc_at) begin
                in_valid = 1'b1;
                in_left  = nl;
                in_right = nr;
            end else begin
                in_valid = 1'b0;
            end
            if (i == en_off_at) enable = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic check_idle(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            check_eq($sformatf("%s_bclk[%0d]", tag, i), bclk, 1'b0);
            check_eq($sformatf("%s_lrclk[%0d]", tag, i), lrclk, 1'b0);
            check_eq($sformatf("%s_sdata[%0d]", tag, i), sdata, 1'b0);
            check_eq($sformatf("%s_underrun[%0d]", tag, i), underrun, 1'b0);
            check_eq($sformatf("%s_in_ready[%0d]", tag, i), in_ready, 1'b1);
            @(negedge clk);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        enable   = 1'b0;
        in_valid = 1'b0;
        in_left  = '0;
        in_right = '0;
        repeat (3) @(negedge clk);
        check_idle("reset", 2);

        reset_n = 1'b1;
        enable  = 1'b1;
        check_eq("ready_before_accept", in_ready, 1'b1);
        in_valid = 1'b1;
        in_left  = 16'hA5A5;
        in_right = 16'h0F0F;
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("ready_after_accept", in_ready, 1'b0);
        check_eq("sdata_idle_after_accept", sdata, 1'b0);
        check_eq("lrclk_idle_after_accept", lrclk, 1'b0);
        @(negedge clk);

        // Frame 1 with a second pair accepted mid-frame
        run_frame(16'hA5A5, 16'h0F0F, 1'b0, 1'b0, 40, 16'h8001, 16'h7FFE, -1);
        // Frame 2 back-to-back, nothing queued behind it
        run_frame(16'h8001, 16'h7FFE, 1'b0, 1'b0, -1, 16'h0000, 16'h0000, -1);
        // Frame 3 underruns; a pair arrives exactly on its frame-end edge
        run_frame(16'h0000, 16'h0000, 1'b1, 1'b0, 127, 16'hC3C3, 16'h3C3C, -1);
        // Frame 4 still underruns, the late pair waits in the hold register
        run_frame(16'h0000, 16'h0000, 1'b1, 1'b1, -1, 16'h0000, 16'h0000, -1);
        // Frame 5 carries the late pair; enable dropped at bit_cnt=5
        run_frame(16'hC3C3, 16'h3C3C, 1'b0, 1'b0, -1, 16'h0000, 16'h0000, 21);
        check_idle("after_disable", 8);

        // Reset mid-frame with a second pair held
        enable   = 1'b1;
        in_valid = 1'b1;
        in_left  = 16'hFFFF;
        in_right = 16'h0001;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("rst_frame_sdata0", sdata, 1'b1);
        in_valid = 1'b1;
        in_left  = 16'h1111;
        in_right = 16'h2222;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (79) @(negedge clk);
        check_eq("rst_frame_lrclk_bit20", lrclk, 1'b1);
        check_eq("rst_frame_ready_held", in_ready, 1'b0);
        reset_n = 1'b0;
        @(negedge clk);
        check_eq("rst_pulse_bclk", bclk, 1'b0);
        check_eq("rst_pulse_lrclk", lrclk, 1'b0);
        check_eq("rst_pulse_sdata", sdata, 1'b0);
        check_eq("rst_pulse_ready", in_ready, 1'b1);
        reset_n = 1'b1;
        check_idle("post_reset", 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, default 16, bits per channel sample.
REQ-002 SHALL have parameter BCLK_DIV, default 8, clk cycles per bit-clock period; even and >= 2.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  permits leaving IDLE and continuing past a frame end.
REQ-006 SHALL have port in_valid  input  1  a stereo sample pair is presented.
REQ-007 SHALL have port in_ready  output  1  the pair is accepted on a cycle where in_valid and in_ready are both high.
REQ-008 SHALL have port in_left  input  SAMPLE_WIDTH  left sample, two's complement.
REQ-009 SHALL have port in_right  input  SAMPLE_WIDTH  right sample, two's complement.
REQ-010 SHALL have port bclk  output  1  serial bit clock.
REQ-011 SHALL have port lrclk  output  1  word select: 0 = left, 1 = right.
REQ-012 SHALL have port sdata  output  1  serial data, MSB first.
REQ-013 SHALL have port underrun  output  1  one-cycle pulse when a frame starts with no sample available.

Function
REQ-014 SHALL hold one sample pair in a holding register (hold_full flag); in_ready = !hold_full.
REQ-015 SHALL, on an accepted handshake, capture in_left/in_right into the holding register and set hold_full on the next edge.
REQ-016 SHALL implement two states: IDLE and RUN.
REQ-017 IDLE outputs: bclk=0, lrclk=0, sdata=0; div_cnt and bit_cnt held at 0.
REQ-018 IDLE -> RUN on the edge where enable=1 and hold_full=1; on that edge: shift register <= {left,right}, hold_full <= 0, div_cnt <= 0, bit_cnt <= 0.
REQ-019 In RUN, div_cnt SHALL count 0..BCLK_DIV-1 and wrap to 0.
REQ-020 In RUN, bclk = (div_cnt >= BCLK_DIV/2); the first half-period is low.
REQ-021 sdata SHALL equal the shift-register MSB, so data changes only on bclk falling edges.
REQ-022 On div_cnt wrap, the block SHALL shift left one bit and increment bit_cnt (0..2*SAMPLE_WIDTH-1).
REQ-023 lrclk = RUN && (bit_cnt >= SAMPLE_WIDTH).
REQ-024 Framing SHALL be left-justified: the left MSB starts on bit_cnt 0 with no one-bit delay, and lrclk changes in the same cycle as the MSB.
REQ-025 At a frame end (div_cnt wrap while bit_cnt = 2*SAMPLE_WIDTH-1) with enable=1: bit_cnt <= 0; if hold_full, load the shift register from the holding register and clear hold_full; otherwise load all zeros and pulse underrun high for exactly that next cycle.
REQ-026 At a frame end with enable=0, the block SHALL go to IDLE; the holding register is retained and no underrun is pulsed.
REQ-027 Deasserting enable mid-frame SHALL NOT truncate the frame; it is sampled only at the frame end.
REQ-028 Accept and frame end on the same edge with hold empty: the frame loads zeros and signals underrun, and the accepted pair is stored for the next frame.
REQ-029 Samples SHALL be transmitted bit-exact, with no arithmetic applied.

Reset
REQ-030 While reset_n=0 at a rising clk edge, the block SHALL clear state to IDLE, hold_full to 0, and div_cnt, bit_cnt, shift register and underrun to 0.
REQ-031 During and after reset: in_ready=1, bclk=0, lrclk=0, sdata=0.
REQ-032 Reset asserted mid-frame SHALL abort the frame immediately and discard the held pair.

Verification (SAMPLE_WIDTH=16, BCLK_DIV=4)
REQ-033 Reset, then enable=1, and accept L=16'hA5A5, R=16'h0F0F -> RUN begins 2 cycles after the accept; sdata = 1010_0101_1010_0101 then 0000_1111_0000_1111, each bit 4 cycles; lrclk rises after 64 cycles; frame is 128 cycles.
REQ-034 Back-to-back pairs with a second pair accepted mid-frame -> the second frame starts with no gap, underrun stays 0, and in_ready is low from the accept until the frame-end load.
REQ-035 Single pair followed by no further input -> the next frame is all zeros and underrun is high for exactly 1 cycle at that frame start.
REQ-036 enable dropped at bit_cnt=5 -> the frame completes all 32 bits, then IDLE, with bclk held at 0.
REQ-037 reset_n pulsed low at bit_cnt=20 -> the next cycle shows IDLE outputs, in_ready=1 and hold_full=0.
REQ-038 Accept coinciding with a frame-end edge while hold is empty -> underrun pulses, the frame is zeros, and the following frame carries the accepted pair.
